sprite_blitter: RTL and testbench

Writer-side companion to the VGA scan-out path. It copies rectangular sprite regions from the 640-wide sprite sheet ROM into the 640x480 8-bit palette-index framebuffer RAM, or fills a rectangle with a constant index. Transfers use a valid/ready command handshake, optional transparent-key skipping, and screen-edge clipping. The game processor drives it each frame to redraw the bird, pipes and background.

---
 rtl/video_pkg.sv | 11 +
 rtl/blit_addr_gen.sv | 65 ++++++
 rtl/sprite_blitter.sv | 102 ++++++++++
 tb/tb_sprite_blitter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Screen, sprite sheet and blitter constants shared by the video write path.
package video_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SHEET_W  = 640;
  localparam logic [7:0] TRANSP_IDX = 8'hFF;
  localparam int FB_AW  = 19;
  localparam int ROM_AW = 17;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} blit_state_t;
endpackage

// File: rtl/blit_addr_gen.sv
// Raster walker for the blitter: col/row counters, incremental source and
// destination addresses, last-pixel and off-screen clip flags.
module blit_addr_gen
  import video_pkg::*;
(
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              load,
  input  logic              step,
  input  logic [ROM_AW-1:0] src,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic [9:0]        w,
  input  logic [8:0]        h,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [FB_AW-1:0]  dst_addr,
  output logic              last,
  output logic              clip
);
  logic [9:0]        x_reg, w_reg, col_reg;
  logic [8:0]        y_reg, h_reg, row_reg;
  logic [ROM_AW-1:0] src_base_reg, src_addr_reg;
  logic [FB_AW-1:0]  dst_base_reg, dst_addr_reg;
  logic [FB_AW-1:0]  y_ext, dst_start;
  logic              row_end;

  // y*640 + x built from shifts so no multiplier is inferred
  assign y_ext     = {10'd0, y};
  assign dst_start = (y_ext << 9) + (y_ext << 7) + {9'd0, x};
  assign row_end   = (col_reg == w_reg - 10'd1);

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      x_reg <= '0; y_reg <= '0; w_reg <= '0; h_reg <= '0;
      col_reg <= '0; row_reg <= '0;
      src_base_reg <= '0; src_addr_reg <= '0;
      dst_base_reg <= '0; dst_addr_reg <= '0;
    end else if (load) begin
      x_reg <= x; y_reg <= y; w_reg <= w; h_reg <= h;
      col_reg <= '0; row_reg <= '0;
      src_base_reg <= src; src_addr_reg <= src;
      dst_base_reg <= dst_start; dst_addr_reg <= dst_start;
    end else if (step) begin
      if (row_end) begin
        col_reg      <= '0;
        row_reg      <= row_reg + 9'd1;
        src_base_reg <= src_base_reg + ROM_AW'(SHEET_W);
        src_addr_reg <= src_base_reg + ROM_AW'(SHEET_W);
        dst_base_reg <= dst_base_reg + FB_AW'(SCREEN_W);
        dst_addr_reg <= dst_base_reg + FB_AW'(SCREEN_W);
      end else begin
        col_reg      <= col_reg + 10'd1;
        src_addr_reg <= src_addr_reg + ROM_AW'(1);
        dst_addr_reg <= dst_addr_reg + FB_AW'(1);
      end
    end
  end

  assign rom_addr = src_addr_reg;
  assign dst_addr = dst_addr_reg;
  assign last     = row_end && (row_reg == h_reg - 9'd1);
  // widened compares so x+col / y+row cannot wrap back on screen
  assign clip     = (({1'b0, x_reg} + {1'b0, col_reg}) >= 11'(SCREEN_W)) ||
                    (({1'b0, y_reg} + {1'b0, row_reg}) >= 10'(SCREEN_H));
endmodule

// File: rtl/sprite_blitter.sv
// Sprite sheet to framebuffer blitter: copy or fill a rectangle, with
// transparent-key skipping and screen-edge clipping, one pixel per cycle.
module sprite_blitter
  import video_pkg::*;
(
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iCMD_valid,
  output logic              oCMD_ready,
  input  logic              iCMD_fill,
  input  logic              iCMD_key_en,
  input  logic [ROM_AW-1:0] iCMD_src,
  input  logic [9:0]        iCMD_x,
  input  logic [8:0]        iCMD_y,
  input  logic [9:0]        iCMD_w,
  input  logic [8:0]        iCMD_h,
  input  logic [7:0]        iCMD_color,
  output logic [ROM_AW-1:0] oROM_ADDR,
  input  logic [7:0]        iROM_Q,
  output logic [FB_AW-1:0]  oFB_ADDR,
  output logic [7:0]        oFB_DATA,
  output logic              oFB_WE,
  output logic              oBUSY,
  output logic              oDONE
);
  blit_state_t       state_reg;
  logic              busy_reg, done_reg;
  logic              fill_reg, key_en_reg;
  logic [7:0]        color_reg;
  logic              s1_valid_reg, s1_clip_reg;
  logic [FB_AW-1:0]  s1_addr_reg;
  logic [ROM_AW-1:0] rom_addr;
  logic [FB_AW-1:0]  dst_addr;
  logic              last_pix, clip;
  logic              accept, keyed;
  logic [7:0]        pix_data;

  assign accept = iCMD_valid && !busy_reg;

  blit_addr_gen u_addr_gen (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .load     (accept),
    .step     (state_reg == RUN),
    .src      (iCMD_src),
    .x        (iCMD_x),
    .y        (iCMD_y),
    .w        (iCMD_w),
    .h        (iCMD_h),
    .rom_addr (rom_addr),
    .dst_addr (dst_addr),
    .last     (last_pix),
    .clip     (clip)
  );

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      fill_reg     <= 1'b0;
      key_en_reg   <= 1'b0;
      color_reg    <= '0;
      s1_valid_reg <= 1'b0;
      s1_clip_reg  <= 1'b0;
      s1_addr_reg  <= '0;
    end else begin
      done_reg     <= (state_reg == FIN);
      s1_valid_reg <= (state_reg == RUN);
      s1_clip_reg  <= clip;
      s1_addr_reg  <= dst_addr;
      case (state_reg)
        IDLE: if (accept) begin
          fill_reg   <= iCMD_fill;
          key_en_reg <= iCMD_key_en;
          color_reg  <= iCMD_color;
          busy_reg   <= 1'b1;
          state_reg  <= (iCMD_w == 10'd0 || iCMD_h == 9'd0) ? FIN : RUN;
        end
        RUN:   if (last_pix) state_reg <= DRAIN;
        DRAIN: state_reg <= FIN;
        FIN: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // ROM data arrives in stage 1, so keying is decided against it directly
  assign keyed    = key_en_reg && !fill_reg && (iROM_Q == TRANSP_IDX);
  assign pix_data = fill_reg ? color_reg : iROM_Q;

  assign oFB_WE     = iRST_n && s1_valid_reg && !s1_clip_reg && !keyed;
  assign oFB_DATA   = (iRST_n && s1_valid_reg) ? pix_data : 8'd0;
  assign oFB_ADDR   = iRST_n ? s1_addr_reg : '0;
  assign oROM_ADDR  = iRST_n ? rom_addr : '0;
  assign oBUSY      = iRST_n && busy_reg;
  assign oCMD_ready = !oBUSY;
  assign oDONE      = iRST_n && done_reg;
endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized self-checking bench for sprite_blitter against a raster-loop model.
module tb_sprite_blitter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_fill = 1'b0, cmd_key = 1'b0;
  logic [16:0] cmd_src = '0;
  logic [9:0]  cmd_x = '0, cmd_w = '0;
  logic [8:0]  cmd_y = '0, cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic [16:0] rom_addr;
  logic [7:0]  rom_q = '0;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we, busy, done;

  int total = 0, bad = 0, cyc = 0;
  logic [7:0]  rom [0:131071];
  logic [16:0] rom_log [int];
  int wa_q[$], wd_q[$], wc_q[$], done_q[$], acc_q[$];

  sprite_blitter dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iCMD_valid(cmd_valid), .oCMD_ready(cmd_ready),
    .iCMD_fill(cmd_fill), .iCMD_key_en(cmd_key), .iCMD_src(cmd_src), .iCMD_x(cmd_x),
    .iCMD_y(cmd_y), .iCMD_w(cmd_w), .iCMD_h(cmd_h), .iCMD_color(cmd_color),
    .oROM_ADDR(rom_addr), .iROM_Q(rom_q), .oFB_ADDR(fb_addr), .oFB_DATA(fb_data),
    .oFB_WE(fb_we), .oBUSY(busy), .oDONE(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q <= rom[rom_addr];

  always @(negedge clk) begin
    if (fb_we) begin
      wa_q.push_back(int'(fb_addr)); wd_q.push_back(int'(fb_data)); wc_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
    rom_log[cyc] = rom_addr;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); done_q.delete(); acc_q.delete();
  endtask

  task automatic drive(input bit fill, input bit key, input int src, input int x,
                       input int y, input int w, input int h, input int color);
    cmd_fill = fill; cmd_key = key; cmd_src = 17'(src); cmd_x = 10'(x);
    cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h); cmd_color = 8'(color);
  endtask

  // Issue one command, wait for completion, and compare against the model.
  task automatic blit(input string name, input bit fill, input bit key, input int src,
                      input int x, input int y, input int w, input int h, input int color);
    int acc, n, ea[$], ed[$], ec[$];
    clear_logs();
    @(posedge clk); #1;
    drive(fill, key, src, x, y, w, h, color);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (acc_q.size() != 1) begin
      chk({name, "_accept"}, acc_q.size(), 1);
      return;
    end
    acc = acc_q[0];
    n = 0;
    while (done_q.size() == 0 && n < w * h + 50) begin
      @(posedge clk); #1; n++;
    end
    repeat (4) @(posedge clk);
    #1;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int i;
        int sa;
        int d;
        i  = r * w + c;
        sa = (src + r * 640 + c) % 131072;
        if (!fill) chk({name, "_rom_addr"}, int'(rom_log[acc + 1 + i]), sa);
        d = fill ? color : int'(rom[sa]);
        if ((x + c) < 640 && (y + r) < 480 && !(!fill && key && d == 255)) begin
          ea.push_back((y + r) * 640 + x + c); ed.push_back(d); ec.push_back(acc + 2 + i);
        end
      end
    end
    chk({name, "_nwrites"}, wa_q.size(), ea.size());
    for (int k = 0; k < ea.size() && k < wa_q.size(); k++) begin
      chk({name, "_fb_addr"}, wa_q[k], ea[k]);
      chk({name, "_fb_data"}, wd_q[k], ed[k]);
      chk({name, "_wr_cycle"}, wc_q[k], ec[k]);
    end
    chk({name, "_ndone"}, done_q.size(), 1);
    if (done_q.size() > 0)
      chk({name, "_done_lat"}, done_q[0] - acc, (w == 0 || h == 0) ? 2 : w * h + 3);
    $display("cmd %s fill=%0d key=%0d %0dx%0d at (%0d,%0d) writes=%0d done=+%0d",
             name, fill, key, w, h, x, y, wa_q.size(),
             done_q.size() > 0 ? done_q[0] - acc : -1);
  endtask

  initial begin
    int acc, rc, pre, post, n;
    for (int i = 0; i < 131072; i++) rom[i] = 8'($urandom);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(fb_we), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_fb_data", int'(fb_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    blit("copy4x2", 0, 0, 82, 100, 50, 4, 2, 0);
    blit("fill3x3", 1, 0, 0, 0, 0, 3, 3, 8'h12);
    blit("clip8x4", 0, 0, 5000, 636, 478, 8, 4, 0);

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        rom[1000 + r * 640 + c] = (c == 2) ? 8'hFF : 8'($urandom_range(0, 254));
    blit("keyed", 0, 1, 1000, 20, 30, 5, 3, 0);
    blit("unkeyed", 0, 0, 1000, 20, 30, 5, 3, 0);
    blit("fill_keyen", 1, 1, 0, 40, 40, 4, 2, 8'hFF);
    blit("degenerate", 0, 0, 0, 5, 5, 0, 7, 0);

    for (int t = 0; t < 8; t++)
      blit("random", 1'($urandom), 1'($urandom), int'($urandom_range(0, 131071)),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
           int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
           int'($urandom_range(0, 255)));

    // command held valid while busy: second accept lands only once the first completes
    clear_logs();
    @(posedge clk); #1;
    drive(0, 0, 300, 10, 10, 2, 2, 0);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 1, 0, 7, 0);
    n = 0;
    while (acc_q.size() < 2 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("held_naccept", acc_q.size(), 2);
    chk("held_ndone", done_q.size(), 2);
    if (acc_q.size() == 2 && done_q.size() == 2) begin
      chk("held_second_accept", acc_q[1] - acc_q[0], 7);
      chk("held_after_done", int'(acc_q[1] >= done_q[0]), 1);
      chk("held_second_done", done_q[1] - acc_q[1], 2);
    end
    $display("cmd held_valid accepts=%0d dones=%0d", acc_q.size(), done_q.size());

    // reset asserted while pixel 5 of a 10x10 copy is being issued
    clear_logs();
    @(posedge clk); #1;
    drive(0, 0, 2000, 10, 10, 10, 10, 0);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc = (acc_q.size() > 0) ? acc_q[0] : cyc - 1;
    while (cyc < acc + 6) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    rc = cyc;
    @(negedge clk);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_we", int'(fb_we), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    pre = 0; post = 0;
    foreach (wc_q[k]) if (wc_q[k] < rc) pre++; else post++;
    chk("midrst_writes_before", pre, 4);
    chk("midrst_writes_after", post, 0);
    chk("midrst_done", done_q.size(), 0);
    chk("midrst_idle_ready", int'(cmd_ready), 1);
    $display("cmd reset_mid_copy writes_before=%0d writes_after=%0d dones=%0d",
             pre, post, done_q.size());

    blit("post_reset", 0, 0, 123, 600, 470, 6, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
